// File: rtl/aes_ks_pkg.sv
// Shared types, constants and the GF(2^8) doubling helper for the key-schedule sequencer.
package aes_ks_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXPAND,
    PRESENT,
    DONE
  } state_e;

  localparam int unsigned NUM_ROUNDS_AES128  = 10;
  localparam int unsigned INNER_LAST_DEFAULT = 15;
  localparam logic [7:0]  RCON_INIT          = 8'h01;
  localparam logic [7:0]  RCON_POLY          = 8'h1b;

  // Multiply by x in GF(2^8), reducing by the AES polynomial on overflow.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    logic [7:0] shifted;
    shifted = {b[6:0], 1'b0};
    return b[7] ? (shifted ^ RCON_POLY) : shifted;
  endfunction

endpackage

// File: rtl/aes_key_schedule_sequencer_rcon_gen.sv
// Rcon register: reloads its initial value on init/clear, doubles in GF(2^8) on advance.
module aes_rcon_gen #(
  parameter logic [7:0] INIT = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic       advance,
  input  logic       clear,
  output logic [7:0] rcon
);
  import aes_ks_pkg::*;

  logic [7:0] rcon_q;
  logic [7:0] rcon_d;

  // Next Rcon: clear and init both restore the round-1 value; advance applies xtime.
  always_comb begin
    rcon_d = rcon_q;
    if (clear || init) begin
      rcon_d = INIT;
    end else if (advance) begin
      rcon_d = xtime(rcon_q);
    end
  end

  // Rcon state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcon_q <= INIT;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon = rcon_q;

endmodule

// File: rtl/aes_key_schedule_sequencer.sv
// Key-schedule sequencer: steps the inner counter, round counter and Rcon,
// and hands each finished round key to the datapath over valid/ready.
module aes_key_schedule_sequencer #(
  parameter int unsigned NUM_ROUNDS = aes_ks_pkg::NUM_ROUNDS_AES128,
  parameter int unsigned INNER_LAST = aes_ks_pkg::INNER_LAST_DEFAULT,
  parameter logic [7:0]  RCON_INIT  = aes_ks_pkg::RCON_INIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       rk_ready,
  output logic       load_key,
  output logic       step_en,
  output logic [3:0] inner_state_counter,
  output logic [3:0] round_num,
  output logic [7:0] rcon,
  output logic       rk_valid,
  output logic       busy,
  output logic       done
);
  import aes_ks_pkg::*;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [3:0] LAST_STEP  = 4'(INNER_LAST);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] round_q, round_d;
  logic       rcon_init, rcon_adv, rcon_clr;

  // Next-state logic; the counter defaults to 0 so it is only non-zero inside EXPAND.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    round_d   = round_q;
    rcon_init = 1'b0;
    rcon_adv  = 1'b0;
    rcon_clr  = 1'b0;
    if (abort) begin
      state_d  = IDLE;
      round_d  = '0;
      rcon_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = LOAD;
            round_d   = '0;
            rcon_init = 1'b1;
          end
        end
        LOAD: state_d = PRESENT;
        EXPAND: begin
          if (cnt_q == LAST_STEP) begin
            state_d = PRESENT;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        PRESENT: begin
          if (rk_ready) begin
            if (round_q == LAST_ROUND) begin
              state_d = DONE;
            end else begin
              state_d  = EXPAND;
              round_d  = round_q + 4'd1;
              // Rounds 0 and 1 share the initial Rcon, so accepting round 0 does not advance it.
              rcon_adv = (round_q != '0);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, inner counter and round registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
    end
  end

  aes_rcon_gen #(
    .INIT(RCON_INIT)
  ) u_rcon (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (rcon_init),
    .advance(rcon_adv),
    .clear  (rcon_clr),
    .rcon   (rcon)
  );

  assign load_key            = (state_q == LOAD);
  assign step_en             = (state_q == EXPAND);
  assign rk_valid            = (state_q == PRESENT);
  assign done                = (state_q == DONE);
  assign busy                = (state_q != IDLE);
  assign inner_state_counter = cnt_q;
  assign round_num           = round_q;

endmodule

// File: tb/tb_aes_key_schedule_sequencer.sv
// Directed, table-driven bench for aes_key_schedule_sequencer.
module tb_aes_key_schedule_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       rk_ready;
  logic       load_key;
  logic       step_en;
  logic [3:0] inner_state_counter;
  logic [3:0] round_num;
  logic [7:0] rcon;
  logic       rk_valid;
  logic       busy;
  logic       done;

  aes_key_schedule_sequencer #(
    .NUM_ROUNDS(10),
    .INNER_LAST(15),
    .RCON_INIT (8'h01)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .abort              (abort),
    .rk_ready           (rk_ready),
    .load_key           (load_key),
    .step_en            (step_en),
    .inner_state_counter(inner_state_counter),
    .round_num          (round_num),
    .rcon               (rcon),
    .rk_valid           (rk_valid),
    .busy               (busy),
    .done               (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       lk;
    logic       se;
    logic [3:0] cnt;
    logic       vld;
    logic [3:0] rnd;
    logic [7:0] rc;
    logic       dn;
    logic       bsy;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl [NVEC];

  int checks = 0;
  int errors = 0;

  localparam logic [20:0] RESET_VEC = {1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 8'h01, 1'b0, 1'b0};

  function automatic logic [20:0] obs();
    return {load_key, step_en, inner_state_counter, rk_valid, round_num, rcon, done, busy};
  endfunction

  function automatic logic [20:0] exp_of(input vec_t v);
    return {v.lk, v.se, v.cnt, v.vld, v.rnd, v.rc, v.dn, v.bsy};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full schedule; stall cycles of rk_ready=0 are inserted at round 4's presentation.
  task automatic run_sched(input string tag, input int stall, input bit poke_start);
    int done_cnt;
    int done_cyc;
    int vld_cnt;
    int last;
    done_cnt = 0;
    done_cyc = -1;
    vld_cnt  = 0;
    last     = 175 + stall;
    for (int cyc = 0; cyc <= last; cyc++) begin
      start    = (cyc == 0) || (poke_start && cyc == 25);
      rk_ready = !(cyc >= 70 && cyc < 70 + stall);
      for (int i = 0; i < NVEC; i++) begin
        int c;
        c = tbl[i].cyc + ((tbl[i].cyc > 70) ? stall : 0);
        if (c == cyc) chk($sformatf("%s cyc%0d", tag, cyc), 32'(obs()), 32'(exp_of(tbl[i])));
      end
      if (stall > 0 && cyc > 70 && cyc <= 70 + stall)
        chk($sformatf("%s stall cyc%0d", tag, cyc), 32'(obs()), 32'(exp_of(tbl[7])));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (rk_valid && rk_ready) vld_cnt++;
      tick();
    end
    start    = 1'b0;
    rk_ready = 1'b1;
    chk({tag, " done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, " done_cycle"}, 32'(done_cyc), 32'(173 + stall));
    chk({tag, " accepts"}, 32'(vld_cnt), 32'd11);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int strobes;
    int dones;
    int busies;

    //                cyc lk  se  cnt vld rnd rcon   dn  bsy
    tbl[0]  = '{  1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd0,  8'h01, 1'b0, 1'b1};
    tbl[1]  = '{  2, 1'b0, 1'b0, 4'd0,  1'b1, 4'd0,  8'h01, 1'b0, 1'b1};
    tbl[2]  = '{  3, 1'b0, 1'b1, 4'd0,  1'b0, 4'd1,  8'h01, 1'b0, 1'b1};
    tbl[3]  = '{ 18, 1'b0, 1'b1, 4'd15, 1'b0, 4'd1,  8'h01, 1'b0, 1'b1};
    tbl[4]  = '{ 19, 1'b0, 1'b0, 4'd0,  1'b1, 4'd1,  8'h01, 1'b0, 1'b1};
    tbl[5]  = '{ 36, 1'b0, 1'b0, 4'd0,  1'b1, 4'd2,  8'h02, 1'b0, 1'b1};
    tbl[6]  = '{ 53, 1'b0, 1'b0, 4'd0,  1'b1, 4'd3,  8'h04, 1'b0, 1'b1};
    tbl[7]  = '{ 70, 1'b0, 1'b0, 4'd0,  1'b1, 4'd4,  8'h08, 1'b0, 1'b1};
    tbl[8]  = '{ 71, 1'b0, 1'b1, 4'd0,  1'b0, 4'd5,  8'h10, 1'b0, 1'b1};
    tbl[9]  = '{ 87, 1'b0, 1'b0, 4'd0,  1'b1, 4'd5,  8'h10, 1'b0, 1'b1};
    tbl[10] = '{104, 1'b0, 1'b0, 4'd0,  1'b1, 4'd6,  8'h20, 1'b0, 1'b1};
    tbl[11] = '{121, 1'b0, 1'b0, 4'd0,  1'b1, 4'd7,  8'h40, 1'b0, 1'b1};
    tbl[12] = '{138, 1'b0, 1'b0, 4'd0,  1'b1, 4'd8,  8'h80, 1'b0, 1'b1};
    tbl[13] = '{155, 1'b0, 1'b0, 4'd0,  1'b1, 4'd9,  8'h1b, 1'b0, 1'b1};
    tbl[14] = '{172, 1'b0, 1'b0, 4'd0,  1'b1, 4'd10, 8'h36, 1'b0, 1'b1};
    tbl[15] = '{173, 1'b0, 1'b0, 4'd0,  1'b0, 4'd10, 8'h36, 1'b1, 1'b1};
    tbl[16] = '{174, 1'b0, 1'b0, 4'd0,  1'b0, 4'd10, 8'h36, 1'b0, 1'b0};
    tbl[17] = '{ 44, 1'b0, 1'b1, 4'd7,  1'b0, 4'd3,  8'h04, 1'b0, 1'b1};

    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    rk_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(obs()), 32'(RESET_VEC));
    rst_n = 1'b1;
    tick();

    run_sched("run1", 0, 1'b1);
    run_sched("run2", 0, 1'b0);
    run_sched("stall", 5, 1'b0);

    // abort at counter 9 of round 6
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (96) tick();
    chk("abort_pre", 32'({round_num, inner_state_counter, step_en}), 32'({4'd6, 4'd9, 1'b1}));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", 32'(obs()), 32'(RESET_VEC));
    dones  = 0;
    busies = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) dones++;
      if (busy) busies++;
      tick();
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    chk("abort_stays_idle", 32'(busies), 32'd0);

    // abort and start together in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_idle", 32'(obs()), 32'(RESET_VEC));
    tick();
    chk("abort_start_idle2", 32'(obs()), 32'(RESET_VEC));

    // asynchronous reset mid-EXPAND at round 3 counter 7
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (43) tick();
    chk("rst_pre", 32'({round_num, inner_state_counter, step_en}), 32'({4'd3, 4'd7, 1'b1}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'(obs()), 32'(RESET_VEC));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (load_key || step_en || rk_valid || done || busy) strobes++;
    end
    chk("rst_no_strobes", 32'(strobes), 32'd0);
    chk("rst_final", 32'(obs()), 32'(RESET_VEC));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule_sequencer.md
Name: aes_key_schedule_sequencer

Overview:
Sequencing stage directly upstream of the key-schedule generator controller.
- Owns the 4-bit inner_state_counter that the controller decodes into en_rcon / en_rot_word / add_* strobes.
- Also owns the round counter and the Rcon register.
- Presents each finished round key to the cipher datapath through a valid/ready handshake, with stall support.

Parameters:
NUM_ROUNDS, 10, last round index (AES-128).
INNER_LAST, 15, final inner_state_counter value of one expansion round.
RCON_INIT, 8'h01, Rcon value used for round 1.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  begin a schedule; sampled only in IDLE.
abort  in  1  synchronous abort; return to IDLE.
rk_ready  in  1  consumer accepts the current round key.
load_key  out  1  one-cycle strobe: load the cipher key into the schedule registers.
step_en  out  1  high while expanding; qualifies the controller strobes.
inner_state_counter  out  4  step index within the round; feeds the controller.
round_num  out  4  round index of the key being built or presented.
rcon  out  8  Rcon for the current round.
rk_valid  out  1  round key round_num is stable on the datapath.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse after round NUM_ROUNDS is accepted.

Behaviour:
- Reset (async, rst_n low):
  - State IDLE.
  - inner_state_counter = 0, round_num = 0, rcon = RCON_INIT.
  - All 1-bit outputs 0.
- States:
  - IDLE: start=1 -> LOAD; otherwise stay.
  - LOAD: load_key=1 for exactly one cycle. round_num=0, rcon=RCON_INIT. -> PRESENT.
  - EXPAND: step_en=1.
    - Counter increments by 1 each cycle, from 0 to INNER_LAST.
    - At INNER_LAST -> PRESENT. Counter returns to 0 on that edge.
  - PRESENT: rk_valid=1; counter held at 0.
    - rk_ready=0: hold all outputs unchanged (stall, any length).
    - rk_ready=1 and round_num<NUM_ROUNDS: round_num+1 -> EXPAND.
    - Rcon update on that accept: if the accepted round_num>=1, rcon <= xtime(rcon). Round 0 acceptance leaves rcon at RCON_INIT.
    - rk_ready=1 and round_num==NUM_ROUNDS: -> DONE.
  - DONE: done=1 for one cycle. -> IDLE. round_num and rcon hold until the next LOAD.
- xtime rule: if rcon[7]==0 then {rcon[6:0],0}, else {rcon[6:0],0} ^ 8'h1b.
  - Required sequence for rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
- step_en is 0 outside EXPAND. The counter is forced to 0 outside EXPAND, so the controller never sees a stale index.
- start is ignored while busy; it is neither queued nor latched.
- abort:
  - Has priority over every other transition in every state.
  - Next state IDLE, with counter and round_num cleared and rcon=RCON_INIT.
  - done does not pulse.
  - abort and start together in IDLE: abort wins, stay IDLE.
- Timing with rk_ready held 1 and start high at cycle 0:
  - load_key at cycle 1.
  - Round r rk_valid at cycle 2+17r.
  - Round 10 at cycle 172; done at cycle 173; IDLE at cycle 174.
- Width rules:
  - round_num never exceeds NUM_ROUNDS.
  - The counter never exceeds INNER_LAST; no wrap occurs inside EXPAND.
- Reset mid-schedule: immediate return to reset values, with no further strobes.

Decomposition:
- Package aes_ks_pkg:
  - state enum (IDLE, LOAD, EXPAND, PRESENT, DONE).
  - Constants: NUM_ROUNDS_AES128=10, INNER_LAST_DEFAULT=15, RCON_INIT=8'h01, RCON_POLY=8'h1b.
  - Function xtime(byte).
- Sub-module aes_rcon_gen: 8-bit Rcon register with init, advance and clear inputs; applies xtime on advance. Same clock and reset as the parent.

Test Plan:
- Reset with rst_n low mid-EXPAND (round 3, counter 7) -> all outputs 0, round_num=0, rcon=01 asynchronously; no strobe after release.
- start pulse, rk_ready tied 1 -> load_key at cycle 1; rk_valid at cycles 2,19,...,172 with round_num 0..10; done at cycle 173 only.
- Rcon check: sample rcon at each rk_valid for rounds 1..10 -> 01,02,04,08,10,20,40,80,1b,36; round 0 reads 01.
- Stall: hold rk_ready=0 for 5 cycles at round 4 -> rk_valid, round_num=4, rcon=08 and counter=0 stable; EXPAND resumes the cycle after rk_ready=1; total latency +5.
- start reasserted during EXPAND of round 2 -> ignored; schedule and done timing unchanged. Second start after done -> fresh schedule, rcon restarts at 01.
- abort at counter 9 of round 6 -> IDLE next cycle, busy=0, round_num=0, rcon=01, no done. abort+start together in IDLE -> stays IDLE.
